// File: rtl/i2c_gain_slave_if.sv
`timescale 1ns/1ps
// I2C pad-side bus: the SDA line is modelled as a wired-AND of the master level and
// the slave pull-down, so the slave only ever sinks the line (open drain).
interface i2c_gain_slave_if;
    logic scl;
    logic sda_m;
    logic sda_oe;
    logic sda;

    assign sda = sda_m & ~sda_oe;

    modport slave  (input scl, input sda, output sda_oe);
    modport master (output scl, output sda_m, input sda, input sda_oe);
endinterface

// File: rtl/i2c_gain_slave.sv
`timescale 1ns/1ps
// I2C slave register bank for the ten equalizer band gains (pointer 0x01..0x0A).
// Define I2C_GAIN_READ_EN to compile the read-back path; otherwise reads are NACKed.
module i2c_gain_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h6A,
    parameter logic [7:0] GAIN_RST   = 8'd10
) (
    input  logic            clk,
    input  logic            rst_n,
    i2c_gain_slave_if.slave bus,
    output logic [7:0]      gain_1,
    output logic [7:0]      gain_2,
    output logic [7:0]      gain_3,
    output logic [7:0]      gain_4,
    output logic [7:0]      gain_5,
    output logic [7:0]      gain_6,
    output logic [7:0]      gain_7,
    output logic [7:0]      gain_8,
    output logic [7:0]      gain_9,
    output logic [7:0]      gain_10,
    output logic [7:0]      reg_addr,
    output logic [7:0]      reg_data,
    output logic            reg_we
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ACK, PTR, WDATA, IGNORE
`ifdef I2C_GAIN_READ_EN
        , RDATA, RACK, RLOAD
`endif
    } state_t;

    logic       scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d, scl_prev_q, scl_prev_d;
    logic       sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d, sda_prev_q, sda_prev_d;
    state_t     state_q, state_d, ack_nxt_q, ack_nxt_d;
    logic       ack_drv_q, ack_drv_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] gain_q [10];
    logic [7:0] gain_d [10];
    logic [7:0] reg_addr_q, reg_addr_d, reg_data_q, reg_data_d;
    logic       reg_we_q, reg_we_d;

    logic       scl_rise, scl_fall, start_c, stop_c, rx_state, byte_done, in_range;
    logic [7:0] rx_byte;
    logic [3:0] gidx;
`ifdef I2C_GAIN_READ_EN
    logic [7:0] tx_byte;
`endif

    always_comb begin
        scl_meta_d = bus.scl;
        scl_sync_d = scl_meta_q;
        scl_prev_d = scl_sync_q;
        sda_meta_d = bus.sda;
        sda_sync_d = sda_meta_q;
        sda_prev_d = sda_sync_q;

        scl_rise  = scl_sync_q & ~scl_prev_q;
        scl_fall  = ~scl_sync_q & scl_prev_q;
        start_c   = scl_sync_q & ~sda_sync_q & sda_prev_q;
        stop_c    = scl_sync_q & sda_sync_q & ~sda_prev_q;
        rx_byte   = {shift_q[6:0], sda_sync_q};
        in_range  = (ptr_q >= 8'd1) && (ptr_q <= 8'd10);
        gidx      = ptr_q[3:0] - 4'd1;
        rx_state  = (state_q == ADDR) || (state_q == PTR) || (state_q == WDATA);
        byte_done = rx_state && scl_rise && (bit_cnt_q == 3'd7);
`ifdef I2C_GAIN_READ_EN
        tx_byte   = in_range ? gain_q[gidx] : 8'h00;
`endif

        state_d    = state_q;
        ack_nxt_d  = ack_nxt_q;
        ack_drv_d  = ack_drv_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        gain_d     = gain_q;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        reg_we_d   = 1'b0;

        // Bus conditions override everything, so a partial byte is simply dropped.
        if (stop_c) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else if (start_c) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else begin
            if (rx_state && scl_rise) begin
                shift_d   = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
                state_d   = ACK;
                ack_drv_d = 1'b0;
                case (state_q)
                    ADDR: begin
                        if (rx_byte[7:1] != SLAVE_ADDR) begin
                            state_d = IGNORE;
                        end else if (rx_byte[0]) begin
`ifdef I2C_GAIN_READ_EN
                            ack_nxt_d = RDATA;
`else
                            state_d = IGNORE;
`endif
                        end else begin
                            ack_nxt_d = PTR;
                        end
                    end
                    PTR: begin
                        ptr_d     = rx_byte;
                        ack_nxt_d = WDATA;
                    end
                    default: begin
                        ptr_d     = ptr_q + 8'd1;
                        ack_nxt_d = WDATA;
                        if (in_range) begin
                            gain_d[gidx] = rx_byte;
                            reg_addr_d   = ptr_q;
                            reg_data_d   = rx_byte;
                            reg_we_d     = 1'b1;
                        end
                    end
                endcase
            end

            case (state_q)
                ACK: begin
                    // First fall after bit 8 starts the pull-down, the next one ends it.
                    if (scl_fall) begin
                        if (!ack_drv_q) begin
                            ack_drv_d = 1'b1;
                            sda_oe_d  = 1'b1;
                        end else begin
                            ack_drv_d = 1'b0;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = ack_nxt_q;
`ifdef I2C_GAIN_READ_EN
                            if (ack_nxt_q == RDATA) begin
                                shift_d  = tx_byte;
                                sda_oe_d = ~tx_byte[7];
                            end
`endif
                        end
                    end
                end
`ifdef I2C_GAIN_READ_EN
                RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = RACK;
                        end else begin
                            sda_oe_d  = ~shift_q[6];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (sda_sync_q) begin
                            state_d = IGNORE;
                        end else begin
                            ptr_d   = ptr_q + 8'd1;
                            state_d = RLOAD;
                        end
                    end
                end
                RLOAD: begin
                    if (scl_fall) begin
                        shift_d   = tx_byte;
                        sda_oe_d  = ~tx_byte[7];
                        bit_cnt_d = 3'd0;
                        state_d   = RDATA;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            ack_nxt_q  <= IDLE;
            ack_drv_q  <= 1'b0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            ptr_q      <= 8'h00;
            sda_oe_q   <= 1'b0;
            for (int i = 0; i < 10; i++) gain_q[i] <= GAIN_RST;
            reg_addr_q <= 8'h00;
            reg_data_q <= 8'h00;
            reg_we_q   <= 1'b0;
        end else begin
            scl_meta_q <= scl_meta_d;
            scl_sync_q <= scl_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            ack_nxt_q  <= ack_nxt_d;
            ack_drv_q  <= ack_drv_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            gain_q     <= gain_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            reg_we_q   <= reg_we_d;
        end
    end

    assign bus.sda_oe = sda_oe_q;
    assign gain_1     = gain_q[0];
    assign gain_2     = gain_q[1];
    assign gain_3     = gain_q[2];
    assign gain_4     = gain_q[3];
    assign gain_5     = gain_q[4];
    assign gain_6     = gain_q[5];
    assign gain_7     = gain_q[6];
    assign gain_8     = gain_q[7];
    assign gain_9     = gain_q[8];
    assign gain_10    = gain_q[9];
    assign reg_addr   = reg_addr_q;
    assign reg_data   = reg_data_q;
    assign reg_we     = reg_we_q;
endmodule

// File: tb/tb_i2c_gain_slave.sv
`timescale 1ns/1ps
// Directed bench for i2c_gain_slave: a bit-banged I2C master writes (and optionally
// reads) the gain bank; expected values are hand-computed constants.
module tb_i2c_gain_slave;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] gain_1, gain_2, gain_3, gain_4, gain_5, gain_6, gain_7, gain_8, gain_9, gain_10;
    logic [7:0] reg_addr, reg_data;
    logic       reg_we;
    logic [7:0] gv [10];

    int         n_chk = 0;
    int         n_err = 0;
    int         we_cnt = 0;
    logic [7:0] we_addr [64];
    logic [7:0] we_data [64];

    i2c_gain_slave_if bus ();

    i2c_gain_slave dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .gain_1  (gain_1),
        .gain_2  (gain_2),
        .gain_3  (gain_3),
        .gain_4  (gain_4),
        .gain_5  (gain_5),
        .gain_6  (gain_6),
        .gain_7  (gain_7),
        .gain_8  (gain_8),
        .gain_9  (gain_9),
        .gain_10 (gain_10),
        .reg_addr(reg_addr),
        .reg_data(reg_data),
        .reg_we  (reg_we)
    );

    always #10 clk = ~clk;

    always_comb begin
        gv[0] = gain_1;  gv[1] = gain_2;  gv[2] = gain_3;  gv[3] = gain_4;  gv[4] = gain_5;
        gv[5] = gain_6;  gv[6] = gain_7;  gv[7] = gain_8;  gv[8] = gain_9;  gv[9] = gain_10;
    end

    // Log every write strobe; a strobe lasting two cycles would be logged twice.
    always @(negedge clk) begin
        if (reg_we) begin
            if (we_cnt < 64) begin
                we_addr[we_cnt] = reg_addr;
                we_data[we_cnt] = reg_data;
            end
            we_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic i2c_start();
        if (bus.scl == 1'b0) begin
            #80 bus.sda_m = 1'b1;
            #20 bus.scl = 1'b1;
            #100;
        end
        bus.sda_m = 1'b0;
        #100 bus.scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #80 bus.sda_m = 1'b0;
        #20 bus.scl = 1'b1;
        #100 bus.sda_m = 1'b1;
        #100;
    endtask

    task automatic send_bit(input logic b);
        #80 bus.sda_m = b;
        #20 bus.scl = 1'b1;
        #100 bus.scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        #80 bus.sda_m = 1'b1;
        #20 bus.scl = 1'b1;
        #50 ack = bus.sda;
        #50 bus.scl = 1'b0;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            if (i == 7) begin
                #20 bus.sda_m = 1'b1;
                #80;
            end else begin
                #100;
            end
            bus.scl = 1'b1;
            #50 d[i] = bus.sda;
            #50 bus.scl = 1'b0;
        end
        #80 bus.sda_m = nack;
        #20 bus.scl = 1'b1;
        #100 bus.scl = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       a;
        logic [7:0] d;
        int         acks;
        int         base;

        bus.scl   = 1'b1;
        bus.sda_m = 1'b1;
        #103 rst_n = 1'b1;
        #100;

        chk("rst_gain1", gain_1, 8'd10);
        chk("rst_gain10", gain_10, 8'd10);
        chk("rst_reg_addr", reg_addr, 8'h00);
        chk("rst_reg_data", reg_data, 8'h00);
        chk("rst_reg_we", reg_we, 1'b0);
        chk("rst_sda", bus.sda, 1'b1);

        // Wrong device address: no ACK, nothing written.
        i2c_start();
        write_byte(8'hD6, a);
        chk("wrong_addr_ack", a, 1'b1);
        write_byte(8'h01, a);
        write_byte(8'h55, a);
        i2c_stop();
        chk("wrong_addr_we", we_cnt, 0);
        chk("wrong_addr_gain1", gain_1, 8'd10);

        // Burst write of all ten gains.
        acks = 0;
        i2c_start();
        write_byte(8'hD4, a);  if (a == 1'b0) acks++;
        write_byte(8'h01, a);  if (a == 1'b0) acks++;
        for (int i = 0; i < 10; i++) begin
            write_byte(8'd17, a);
            if (a == 1'b0) acks++;
        end
        i2c_stop();
        chk("burst_acks", acks, 12);
        chk("burst_we_cnt", we_cnt, 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("burst_we_addr%0d", i), we_addr[i], i + 1);
            chk($sformatf("burst_we_data%0d", i), we_data[i], 8'd17);
            chk($sformatf("burst_gain%0d", i + 1), gv[i], 8'd17);
        end
        chk("burst_reg_addr", reg_addr, 8'd10);
        chk("burst_reg_data", reg_data, 8'd17);

        // Write running off the end of the bank.
        base = we_cnt;
        acks = 0;
        i2c_start();
        write_byte(8'hD4, a);  if (a == 1'b0) acks++;
        write_byte(8'h09, a);  if (a == 1'b0) acks++;
        write_byte(8'd14, a);  if (a == 1'b0) acks++;
        write_byte(8'd15, a);  if (a == 1'b0) acks++;
        write_byte(8'd16, a);  if (a == 1'b0) acks++;
        i2c_stop();
        chk("edge_acks", acks, 5);
        chk("edge_we_cnt", we_cnt - base, 2);
        chk("edge_gain9", gain_9, 8'd14);
        chk("edge_gain10", gain_10, 8'd15);
        chk("edge_gain8", gain_8, 8'd17);
        chk("edge_ptr", dut.ptr_q, 8'h0C);

        // Reset during bit 4 of a data byte.
        base = we_cnt;
        i2c_start();
        write_byte(8'hD4, a);
        write_byte(8'h01, a);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #80 bus.sda_m = 1'b0;
        #20 bus.scl = 1'b1;
        #50 rst_n = 1'b0;
        #1;
        chk("midrst_sda", bus.sda_oe, 1'b0);
        chk("midrst_gain1", gain_1, 8'd10);
        chk("midrst_gain9", gain_9, 8'd10);
        chk("midrst_gain10", gain_10, 8'd10);
        chk("midrst_reg_addr", reg_addr, 8'h00);
        #99 bus.sda_m = 1'b1;
        #100 rst_n = 1'b1;
        #100;
        chk("midrst_we_cnt", we_cnt - base, 0);

        // Reset while the slave is pulling SDA low in an ACK slot.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 6 || i == 4 || i == 2);
        #80 bus.sda_m = 1'b1;
        #20 bus.scl = 1'b1;
        #50 chk("ackrst_drive", bus.sda, 1'b0);
        rst_n = 1'b0;
        #1 chk("ackrst_release", bus.sda, 1'b1);
        #99 bus.sda_m = 1'b1;
        #100 rst_n = 1'b1;
        #100;

        // A clean write after reset.
        base = we_cnt;
        i2c_start();
        write_byte(8'hD4, a);
        chk("post_rst_ack", a, 1'b0);
        write_byte(8'h02, a);
        write_byte(8'h33, a);
        i2c_stop();
        chk("post_rst_gain2", gain_2, 8'h33);
        chk("post_rst_we_cnt", we_cnt - base, 1);
        chk("post_rst_we_addr", we_addr[base], 8'h02);
        chk("post_rst_gain1", gain_1, 8'd10);

`ifdef I2C_GAIN_READ_EN
        i2c_start();
        write_byte(8'hD4, a);
        write_byte(8'h03, a);
        write_byte(8'h5A, a);
        write_byte(8'hC3, a);
        i2c_stop();
        chk("rd_pre_gain3", gain_3, 8'h5A);
        chk("rd_pre_gain4", gain_4, 8'hC3);
        i2c_start();
        write_byte(8'hD4, a);
        write_byte(8'h03, a);
        i2c_start();
        write_byte(8'hD5, a);
        chk("rd_addr_ack", a, 1'b0);
        read_byte(1'b0, d);
        chk("rd_byte0", d, 8'h5A);
        read_byte(1'b1, d);
        chk("rd_byte1", d, 8'hC3);
        chk("rd_release", bus.sda, 1'b1);
        i2c_stop();
        chk("rd_ptr", dut.ptr_q, 8'h04);
`else
        i2c_start();
        write_byte(8'hD5, a);
        chk("rd_addr_nack", a, 1'b1);
        read_byte(1'b1, d);
        chk("rd_no_drive", d, 8'hFF);
        i2c_stop();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
